aixh_mxc_inner_bwd_drain: RTL and testbench
===========================================

AIXH_MXC_INNER_BWD_DRAIN -- requirements
Module: AIXH_MXC_INNER_bwd_drain

Interface
REQ-001 The block SHALL have parameter YCELLS, default 4: number of backward-result row lanes.
REQ-002 The block SHALL have parameter DWIDTH, default 32: width of one backward-result word.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of two, >=2): per-row FIFO entries.
REQ-004 The block SHALL have port aixh_core_clk2x, input, 1: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port aixh_core_rstn2x, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_bwd_vld, input, YCELLS: per-row result valid; there is no backpressure toward the tile.
REQ-007 The block SHALL have port i_bwd_dat, input, YCELLS*DWIDTH: per-row result data; row y occupies bits [y*DWIDTH +: DWIDTH].
REQ-008 The block SHALL have port o_vld, input/output direction output, 1: a serialized result is available.
REQ-009 The block SHALL have port i_rdy, input, 1: the downstream consumer accepts o_dat when o_vld&i_rdy.
REQ-010 The block SHALL have port o_dat, output, DWIDTH: the serialized result word.
REQ-011 The block SHALL have port o_row, output, clog2(YCELLS): the source row of o_dat.
REQ-012 The block SHALL have port o_ovf, output, YCELLS: sticky per-row overflow flags.
REQ-013 The block SHALL have port i_ovf_clr, input, 1: synchronous clear of all o_ovf bits.
REQ-014 The block SHALL have port o_idle, output, 1: high when all FIFOs are empty and o_vld is low.

Function
REQ-015 Each row SHALL own an independent DEPTH-entry FIFO that is pushed with i_bwd_dat[y] in every cycle where i_bwd_vld[y] is high.
REQ-016 A push to a full FIFO with no same-cycle pop SHALL drop the word, leave the FIFO contents unchanged, and set o_ovf[y] on the next cycle.
REQ-017 A push and a pop on the same full FIFO in the same cycle SHALL both be accepted without setting o_ovf[y].
REQ-018 Each FIFO's read and write pointers SHALL wrap modulo DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-019 The output register (o_vld/o_dat/o_row) SHALL load when (!o_vld | i_rdy) and at least one FIFO is non-empty, popping exactly one word from the granted row.
REQ-020 The grant SHALL be round-robin: the search begins at rr_ptr and selects the first non-empty row at or after it, wrapping from YCELLS-1 to 0.
REQ-021 rr_ptr SHALL become (granted row + 1) mod YCELLS after each grant and SHALL be unchanged otherwise.
REQ-022 When (!o_vld | i_rdy) holds and all FIFOs are empty, o_vld SHALL deassert on the next cycle.
REQ-023 While o_vld&!i_rdy, o_dat and o_row SHALL remain stable.
REQ-024 Latency SHALL be one cycle: a push into an empty FIFO in cycle N, with the output register free, SHALL present o_vld in cycle N+1.
REQ-025 Sustained throughput SHALL be one word per cycle while i_rdy is high.
REQ-026 Words from the same row SHALL leave in arrival order; no word SHALL be duplicated.
REQ-027 When i_ovf_clr coincides with a new overflow on row y, o_ovf[y] SHALL end set and all other bits SHALL end cleared.

Reset
REQ-028 Assertion of aixh_core_rstn2x low SHALL immediately empty all FIFOs and force o_vld=0, o_dat=0, o_row=0, o_ovf=0, rr_ptr=0 and o_idle=1.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words, and after release no stale word SHALL appear on o_dat.
REQ-030 Deassertion SHALL be released synchronously to aixh_core_clk2x by the integrating level; the block itself adds no synchronizer.

Configuration
REQ-031 With AIXH_MXC_BWD_DRAIN_OVF_CNT_EN defined, the block SHALL add an output o_ovf_cnt (16 bits) counting dropped words across all rows, saturating at 0xFFFF, cleared by i_ovf_clr and by reset.
REQ-032 When several rows drop words in one cycle, o_ovf_cnt SHALL increment by the number of dropped words, still saturating at 0xFFFF.
REQ-033 Without AIXH_MXC_BWD_DRAIN_OVF_CNT_EN, port o_ovf_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover: i_rdy=1, i_bwd_vld=4'b1111 for one cycle with data 0x10..0x13 -> o_row sequence 0,1,2,3 with o_dat 0x10..0x13 in four consecutive cycles starting one cycle after the push.
REQ-035 The bench SHALL cover: i_rdy=0, six pushes to row 2 -> four words retained, o_ovf=4'b0100 and o_ovf_cnt=2; after i_rdy=1 exactly four words emerge in order.
REQ-036 The bench SHALL cover: row 1 FIFO full and o_vld&i_rdy popping row 1 while row 1 pushes -> no overflow and FIFO occupancy stays 4.
REQ-037 The bench SHALL cover: rows 0 and 3 continuously valid with i_rdy=1 -> strict alternation 0,3,0,3, after which the FIFOs overflow at the input rate.
REQ-038 The bench SHALL cover: o_vld=1 and i_rdy=0 held for 5 cycles -> o_dat and o_row unchanged; then reset pulsed -> o_vld=0 and o_idle=1 immediately, with no output after release.
REQ-039 The bench SHALL cover: i_ovf_clr=1 together with a new overflow on row 0 while o_ovf=4'b1010 -> o_ovf=4'b0001.

Source files
------------

// File: rtl/aixh_mxc_inner_bwd_drain.sv
// aixh_mxc_inner_bwd_drain
//   Collects backward-pass results from YCELLS row lanes into per-row FIFOs.
//   Drains them onto one valid/ready output stream through a round-robin arbiter.
//   A word arriving at an empty row can go straight to the output register.
//   That bypass gives one cycle of latency from push to o_vld.
//   Optional feature macro: AIXH_MXC_BWD_DRAIN_OVF_CNT_EN adds the 16-bit
//   saturating dropped-word counter o_ovf_cnt.
module aixh_mxc_inner_bwd_drain #(
  parameter int YCELLS = 4,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                                           aixh_core_clk2x,
  input  logic                                           aixh_core_rstn2x,
  input  logic [YCELLS-1:0]                              i_bwd_vld,
  input  logic [YCELLS*DWIDTH-1:0]                       i_bwd_dat,
  output logic                                           o_vld,
  input  logic                                           i_rdy,
  output logic [DWIDTH-1:0]                              o_dat,
  output logic [((YCELLS > 1) ? $clog2(YCELLS) : 1)-1:0] o_row,
  output logic [YCELLS-1:0]                              o_ovf,
  input  logic                                           i_ovf_clr,
  output logic                                           o_idle
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
  ,
  output logic [15:0]                                    o_ovf_cnt
`endif
);

  localparam int RW = (YCELLS > 1) ? $clog2(YCELLS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(YCELLS - 1);

  logic [DWIDTH-1:0] mem    [YCELLS][DEPTH];
  logic [AW:0]       wr_ptr [YCELLS];
  logic [AW:0]       rd_ptr [YCELLS];
  logic [RW-1:0]     rr_ptr;

  logic [YCELLS-1:0] empty, full, avail;
  logic [YCELLS-1:0] push, pop, bypass, drop;
  logic [RW-1:0]     grant;
  logic [RW:0]       idx;
  logic              any_avail;
  logic              out_free;
  logic              load;
  logic [DWIDTH-1:0] grant_dat;

  // Row status: a row competes for the output if it holds a word or is receiving one now
  always_comb begin
    empty = '0;
    full  = '0;
    avail = '0;
    for (int y = 0; y < YCELLS; y++) begin
      empty[y] = (wr_ptr[y] == rd_ptr[y]);
      full[y]  = (wr_ptr[y] == {~rd_ptr[y][AW], rd_ptr[y][AW-1:0]});
      avail[y] = ~empty[y] | i_bwd_vld[y];
    end
  end

  // Round-robin search starting at rr_ptr for the first row with a word to offer
  always_comb begin
    grant     = '0;
    any_avail = 1'b0;
    idx       = '0;
    for (int i = 0; i < YCELLS; i++) begin
      idx = {1'b0, rr_ptr} + (RW+1)'(i);
      if (idx >= (RW+1)'(YCELLS)) begin
        idx = idx - (RW+1)'(YCELLS);
      end
      if (!any_avail && avail[idx[RW-1:0]]) begin
        any_avail = 1'b1;
        grant     = idx[RW-1:0];
      end
    end
  end

  // An empty granted row hands its incoming word straight to the output register
  always_comb begin
    out_free = ~o_vld | i_rdy;
    load     = out_free & any_avail;
    if (empty[grant]) begin
      grant_dat = i_bwd_dat[int'(grant)*DWIDTH +: DWIDTH];
    end else begin
      grant_dat = mem[grant][rd_ptr[grant][AW-1:0]];
    end
  end

  // Per-row push/pop/drop decisions; a pop frees the slot a same-cycle push lands in
  always_comb begin
    push   = '0;
    pop    = '0;
    bypass = '0;
    drop   = '0;
    for (int y = 0; y < YCELLS; y++) begin
      pop[y]    = load & (grant == RW'(y)) & ~empty[y];
      bypass[y] = load & (grant == RW'(y)) & empty[y];
      push[y]   = i_bwd_vld[y] & ~bypass[y] & (~full[y] | pop[y]);
      drop[y]   = i_bwd_vld[y] & full[y] & ~pop[y];
    end
  end

  // FIFO storage is not reset; the pointers alone define which entries are live
  always_ff @(posedge aixh_core_clk2x) begin
    for (int y = 0; y < YCELLS; y++) begin
      if (push[y]) begin
        mem[y][wr_ptr[y][AW-1:0]] <= i_bwd_dat[y*DWIDTH +: DWIDTH];
      end
    end
  end

  // FIFO pointers carry an extra wrap bit so full and empty can be told apart
  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      for (int y = 0; y < YCELLS; y++) begin
        wr_ptr[y] <= '0;
        rd_ptr[y] <= '0;
      end
    end else begin
      for (int y = 0; y < YCELLS; y++) begin
        if (push[y]) wr_ptr[y] <= wr_ptr[y] + 1'b1;
        if (pop[y])  rd_ptr[y] <= rd_ptr[y] + 1'b1;
      end
    end
  end

  // Output register and arbiter pointer advance together on every grant
  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      o_vld  <= 1'b0;
      o_dat  <= '0;
      o_row  <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      o_vld  <= 1'b1;
      o_dat  <= grant_dat;
      o_row  <= grant;
      rr_ptr <= (grant == LAST_ROW) ? '0 : grant + 1'b1;
    end else if (out_free) begin
      o_vld  <= 1'b0;
    end
  end

  // Sticky overflow flags; a clear never hides an overflow happening in the same cycle
  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      o_ovf <= '0;
    end else if (i_ovf_clr) begin
      o_ovf <= drop;
    end else begin
      o_ovf <= o_ovf | drop;
    end
  end

`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
  logic [16:0] cnt_next;

  // Add this cycle's drops (all rows) to the count, restarting from zero on a clear
  always_comb begin
    cnt_next = i_ovf_clr ? 17'd0 : {1'b0, o_ovf_cnt};
    for (int y = 0; y < YCELLS; y++) begin
      cnt_next = cnt_next + 17'(drop[y]);
    end
  end

  // Saturating dropped-word counter
  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      o_ovf_cnt <= '0;
    end else begin
      o_ovf_cnt <= cnt_next[16] ? 16'hFFFF : cnt_next[15:0];
    end
  end
`endif

  assign o_idle = (&empty) & ~o_vld;

endmodule

// File: tb/tb_aixh_mxc_inner_bwd_drain.sv
// Directed testbench for aixh_mxc_inner_bwd_drain (YCELLS=4, DWIDTH=32, DEPTH=4).
// The o_ovf_cnt checks only take effect when AIXH_MXC_BWD_DRAIN_OVF_CNT_EN is defined.
module tb_aixh_mxc_inner_bwd_drain;

  logic         clk;
  logic         rst_n;
  logic [3:0]   i_bwd_vld;
  logic [127:0] i_bwd_dat;
  logic         o_vld;
  logic         i_rdy;
  logic [31:0]  o_dat;
  logic [1:0]   o_row;
  logic [3:0]   o_ovf;
  logic         i_ovf_clr;
  logic         o_idle;
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
  logic [15:0]  o_ovf_cnt;
`endif

  int checks;
  int errors;

  aixh_mxc_inner_bwd_drain #(.YCELLS(4), .DWIDTH(32), .DEPTH(4)) dut (
    .aixh_core_clk2x (clk),
    .aixh_core_rstn2x(rst_n),
    .i_bwd_vld       (i_bwd_vld),
    .i_bwd_dat       (i_bwd_dat),
    .o_vld           (o_vld),
    .i_rdy           (i_rdy),
    .o_dat           (o_dat),
    .o_row           (o_row),
    .o_ovf           (o_ovf),
    .i_ovf_clr       (i_ovf_clr),
    .o_idle          (o_idle)
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
    ,
    .o_ovf_cnt       (o_ovf_cnt)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_bwd_vld = '0;
    i_bwd_dat = '0;
    i_rdy     = 1'b0;
    i_ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    i_bwd_vld = 4'b0110;
    i_bwd_dat = {32'h4, 32'h3, 32'h2, 32'h1};
    step();
    i_bwd_vld = '0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_dat !== 32'h0 || o_row !== 2'd0 || o_ovf !== 4'h0 || o_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: got vld=%b dat=%h row=%0d ovf=%b idle=%b, expected 0/0/0/0000/1",
               o_vld, o_dat, o_row, o_ovf, o_idle);
    end
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
    checks++;
    if (o_ovf_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %h expected 0000", o_ovf_cnt);
    end
`endif
    do_reset();
  endtask

  task automatic test_round_robin_burst();
    logic [31:0] exp_dat;
    do_reset();
    i_rdy     = 1'b1;
    i_bwd_vld = 4'b1111;
    i_bwd_dat = {32'h13, 32'h12, 32'h11, 32'h10};
    step();
    i_bwd_vld = '0;
    for (int k = 0; k < 4; k++) begin
      exp_dat = 32'h10 + 32'(k);
      checks++;
      if (o_vld !== 1'b1 || o_row !== 2'(k) || o_dat !== exp_dat) begin
        errors++;
        $display("[TB] FAIL burst_word%0d: got vld=%b row=%0d dat=%h, expected 1/%0d/%h",
                 k, o_vld, o_row, o_dat, k, exp_dat);
      end
      step();
    end
    checks++;
    if (o_vld !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_end: got vld=%b idle=%b, expected 0/1", o_vld, o_idle);
    end
  endtask

  task automatic test_overflow_retain();
    logic [31:0] exp_dat;
    do_reset();
    i_rdy     = 1'b0;
    i_bwd_vld = 4'b0001;
    i_bwd_dat = '0;
    i_bwd_dat[31:0] = 32'hA0;
    step();
    for (int k = 0; k < 6; k++) begin
      i_bwd_vld = 4'b0100;
      i_bwd_dat = '0;
      i_bwd_dat[64 +: 32] = 32'h21 + 32'(k);
      step();
    end
    i_bwd_vld = '0;
    checks++;
    if (o_ovf !== 4'b0100 || o_vld !== 1'b1 || o_row !== 2'd0 || o_dat !== 32'hA0) begin
      errors++;
      $display("[TB] FAIL ovf_retain_flags: got ovf=%b vld=%b row=%0d dat=%h, expected 0100/1/0/a0",
               o_ovf, o_vld, o_row, o_dat);
    end
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
    checks++;
    if (o_ovf_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL ovf_retain_cnt: got %0d expected 2", o_ovf_cnt);
    end
`endif
    i_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_dat = 32'h21 + 32'(k);
      checks++;
      if (o_vld !== 1'b1 || o_row !== 2'd2 || o_dat !== exp_dat) begin
        errors++;
        $display("[TB] FAIL ovf_retain_word%0d: got vld=%b row=%0d dat=%h, expected 1/2/%h",
                 k, o_vld, o_row, o_dat, exp_dat);
      end
    end
    step();
    checks++;
    if (o_vld !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_retain_drained: got vld=%b idle=%b, expected 0/1", o_vld, o_idle);
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] exp_dat;
    do_reset();
    i_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_bwd_vld = 4'b0010;
      i_bwd_dat = '0;
      i_bwd_dat[32 +: 32] = 32'h31 + 32'(k);
      step();
    end
    i_rdy = 1'b1;
    i_bwd_dat[32 +: 32] = 32'h36;
    step();
    i_bwd_vld = '0;
    i_rdy     = 1'b0;
    checks++;
    if (o_ovf !== 4'b0000 || o_vld !== 1'b1 || o_row !== 2'd1 || o_dat !== 32'h32) begin
      errors++;
      $display("[TB] FAIL full_pop_push: got ovf=%b vld=%b row=%0d dat=%h, expected 0000/1/1/32",
               o_ovf, o_vld, o_row, o_dat);
    end
    step();
    i_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_dat = 32'h33 + 32'(k);
      checks++;
      if (o_vld !== 1'b1 || o_row !== 2'd1 || o_dat !== exp_dat) begin
        errors++;
        $display("[TB] FAIL full_pop_push_drain%0d: got vld=%b row=%0d dat=%h, expected 1/1/%h",
                 k, o_vld, o_row, o_dat, exp_dat);
      end
    end
    step();
    checks++;
    if (o_vld !== 1'b0 || o_ovf !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL full_pop_push_end: got vld=%b ovf=%b, expected 0/0000", o_vld, o_ovf);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] exp_row;
    do_reset();
    i_rdy     = 1'b1;
    i_bwd_vld = 4'b1001;
    i_bwd_dat = {32'h3333, 32'h0, 32'h0, 32'h1111};
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_row = (k % 2 == 1) ? 2'd0 : 2'd3;
      checks++;
      if (o_vld !== 1'b1 || o_row !== exp_row) begin
        errors++;
        $display("[TB] FAIL alternate_row%0d: got vld=%b row=%0d, expected 1/%0d",
                 k, o_vld, o_row, exp_row);
      end
      if (k == 8) begin
        checks++;
        if (o_ovf !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL alternate_no_ovf: got %b expected 0000", o_ovf);
        end
      end
      if (k == 9) begin
        checks++;
        if (o_ovf !== 4'b1000) begin
          errors++;
          $display("[TB] FAIL alternate_ovf_row3: got %b expected 1000", o_ovf);
        end
      end
      if (k == 10) begin
        checks++;
        if (o_ovf !== 4'b1001) begin
          errors++;
          $display("[TB] FAIL alternate_ovf_both: got %b expected 1001", o_ovf);
        end
      end
    end
    i_bwd_vld = '0;
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    i_rdy     = 1'b0;
    i_bwd_vld = 4'b1010;
    i_bwd_dat = {32'h77, 32'h0, 32'h55, 32'h0};
    step();
    i_bwd_vld = '0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_vld !== 1'b1 || o_row !== 2'd1 || o_dat !== 32'h55) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b row=%0d dat=%h, expected 1/1/55",
                 k, o_vld, o_row, o_dat);
      end
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0 || o_idle !== 1'b1 || o_dat !== 32'h0 || o_row !== 2'd0) begin
      errors++;
      $display("[TB] FAIL hold_async_reset: got vld=%b idle=%b dat=%h row=%0d, expected 0/1/0/0",
               o_vld, o_idle, o_dat, o_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (o_vld !== 1'b0 || o_idle !== 1'b1) begin
        errors++;
        $display("[TB] FAIL post_reset_stale%0d: got vld=%b idle=%b dat=%h, expected 0/1",
                 k, o_vld, o_idle, o_dat);
      end
    end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    i_rdy     = 1'b0;
    i_bwd_vld = 4'b1010;
    i_bwd_dat = {32'hD3, 32'h0, 32'hD1, 32'h0};
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        checks++;
        if (o_ovf !== 4'b1000) begin
          errors++;
          $display("[TB] FAIL ovf_first_row3: got %b expected 1000", o_ovf);
        end
      end
    end
    checks++;
    if (o_ovf !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL ovf_rows13: got %b expected 1010", o_ovf);
    end
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
    checks++;
    if (o_ovf_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL ovf_multi_cnt: got %0d expected 3", o_ovf_cnt);
    end
`endif
    i_bwd_vld = 4'b0001;
    i_bwd_dat = {32'h0, 32'h0, 32'h0, 32'hD0};
    repeat (4) step();
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    i_bwd_vld = '0;
    checks++;
    if (o_ovf !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL ovf_clr_with_new: got %b expected 0001", o_ovf);
    end
    step();
    checks++;
    if (o_ovf !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL ovf_sticky_after_clr: got %b expected 0001", o_ovf);
    end
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    checks++;
    if (o_ovf !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL ovf_plain_clr: got %b expected 0000", o_ovf);
    end
`ifdef AIXH_MXC_BWD_DRAIN_OVF_CNT_EN
    checks++;
    if (o_ovf_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL ovf_cnt_clr: got %0d expected 0", o_ovf_cnt);
    end
`endif
  endtask

  // Scenario sequence
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    i_bwd_vld = '0;
    i_bwd_dat = '0;
    i_rdy     = 1'b0;
    i_ovf_clr = 1'b0;
    test_reset();
    test_round_robin_burst();
    test_overflow_retain();
    test_full_pop_push();
    test_alternation();
    test_hold_and_reset();
    test_ovf_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
